// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// PC source select, trap causes and the decoded instruction class.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_TRAP   = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_IRQ     = 2'd1,
    CAUSE_ILLEGAL = 2'd2,
    CAUSE_BUS     = 2'd3
  } trap_cause_e;

  // Coarse instruction class; all the sequencer needs to choose a path.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opc);
    op_class_e cls;
    case (opc)
      OPC_LOAD:                              cls = CLS_LOAD;
      OPC_STORE:                             cls = CLS_STORE;
      OPC_BRANCH:                            cls = CLS_BRANCH;
      OPC_JAL, OPC_JALR:                     cls = CLS_JUMP;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = CLS_ALU;
      default:                               cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rv32i_bus_timeout.sv
// Data-memory wait counter. expired flags the cycle whose increment would
// bring the count to MEM_TIMEOUT, so the sequencer can leave MEM that cycle.
module rv32i_bus_timeout
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  // Next count: clear wins over increment, otherwise hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/rv32i_core_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with trap vectoring for interrupts, illegal opcodes and bus timeouts.
module rv32i_core_sequencer
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 branch_cond,
  input  logic                 mem_ack,
  input  logic                 interrupt_req,
  input  logic                 stall_in,
  output logic [2:0]           state,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write_en,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 trap_taken,
  output logic [1:0]           trap_cause,
  output logic                 exception,
  output logic [CNT_WIDTH-1:0] retired
);

  state_e               state_q, state_d;
  op_class_e            cls_q, cls_d;
  trap_cause_e          cause_q, cause_d;
  logic                 irq_pending_q, irq_pending_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  pc_src_e              pc_src_sel;
  logic                 tmo_en, tmo_clr, tmo_expired;

  rv32i_bus_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_bus_timeout (
    .clk    (clk),
    .reset  (reset),
    .en     (tmo_en),
    .clr    (tmo_clr),
    .expired(tmo_expired)
  );

  // Next state, strobes and trap bookkeeping; stall freezes progress but not the irq latch set
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cause_d       = cause_q;
    irq_pending_d = irq_pending_q | interrupt_req;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_src_sel    = PC_SEQ;
    reg_write_en  = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    trap_taken    = 1'b0;
    tmo_en        = 1'b0;
    tmo_clr       = 1'b0;

    // The memory request is a level that survives stalls; it drops with reset.
    if (reset && state_q == ST_MEM) begin
      mem_req = 1'b1;
      mem_we  = (cls_q == CLS_STORE);
    end

    if (reset && !stall_in) begin
      case (state_q)
        ST_FETCH: begin
          if (irq_pending_q) begin
            state_d       = ST_TRAP;
            cause_d       = CAUSE_IRQ;
            irq_pending_d = 1'b0;
          end else begin
            ir_load = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          cls_d = classify(opcode);
          if (cls_d == CLS_ILLEGAL) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (cls_q)
            CLS_BRANCH: begin
              pc_write   = 1'b1;
              pc_src_sel = branch_cond ? PC_BRANCH : PC_SEQ;
              state_d    = ST_FETCH;
            end
            CLS_JUMP: begin
              reg_write_en = 1'b1;
              pc_write     = 1'b1;
              pc_src_sel   = PC_JUMP;
              state_d      = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            default:             state_d = ST_WRITEBACK;
          endcase
        end
        ST_MEM: begin
          // An ack arriving on the expiry cycle still completes the access.
          if (mem_ack) begin
            tmo_clr = 1'b1;
            if (cls_q == CLS_STORE) begin
              pc_write = 1'b1;
              state_d  = ST_FETCH;
            end else begin
              state_d = ST_WRITEBACK;
            end
          end else begin
            tmo_en = 1'b1;
            if (tmo_expired) begin
              tmo_clr = 1'b1;
              state_d = ST_TRAP;
              cause_d = CAUSE_BUS;
            end
          end
        end
        ST_WRITEBACK: begin
          reg_write_en = 1'b1;
          pc_write     = 1'b1;
          state_d      = ST_FETCH;
        end
        ST_TRAP: begin
          pc_write   = 1'b1;
          pc_src_sel = PC_TRAP;
          trap_taken = 1'b1;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end

    // Every non-trap PC update marks an instruction completing.
    retired_d = retired_q;
    if (pc_write && pc_src_sel != PC_TRAP) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      cls_q         <= CLS_ALU;
      cause_q       <= CAUSE_NONE;
      irq_pending_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      cause_q       <= cause_d;
      irq_pending_q <= irq_pending_d;
      retired_q     <= retired_d;
    end
  end

  assign state      = state_q;
  assign pc_src     = pc_src_sel;
  assign trap_cause = cause_q;
  assign exception  = (cause_q == CAUSE_ILLEGAL) || (cause_q == CAUSE_BUS);
  assign retired    = retired_q;

endmodule
